ifetch: RTL and testbench

Instruction-fetch stage feeding `decode`. It holds the fetch PC and issues in-order word requests to instruction memory over a request/grant port. Returned words are buffered with their PCs in a small FIFO and presented to `decode` through a valid/ready handshake. Redirects come from `decode` (`is_jmp` / `jmp_addr`); on a redirect the block flushes the buffer and squashes in-flight responses.

---
 rtl/ifetch.sv | 68 ++++++
 tb/tb_ifetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: in-order instruction fetch with credit-limited request port, {pc, word} buffer and redirect flush.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        is_jmp,
  input  logic [31:0] jmp_addr,
  output logic [31:0] inst,
  output logic [31:0] PC,
  output logic        inst_valid,
  input  logic        inst_ready
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 3;
  logic          r_run;
  logic [31:0]   r_fpc;
  logic [CW-1:0] r_outst, r_disc, r_count;
  logic [AW-1:0] r_rd, r_wr;
  logic [31:0]   r_pc   [BUF_DEPTH];
  logic [31:0]   r_word [BUF_DEPTH];
  logic          w_gnt, w_drop, w_push, w_pop, w_redir;
  logic [31:0]   w_rsp_pc;
  assign imem_req   = r_run && (r_outst + r_disc + r_count < CW'(BUF_DEPTH));
  assign imem_addr  = r_fpc;
  assign w_gnt      = imem_req & imem_gnt;
  assign w_drop     = imem_rvalid & (r_disc != '0);
  assign w_push     = imem_rvalid & ~w_drop;
  assign inst_valid = r_count != '0;
  assign w_pop      = inst_valid & inst_ready;
  assign w_redir    = w_pop & is_jmp;
  assign inst       = inst_valid ? r_word[r_rd] : '0;
  assign PC         = inst_valid ? r_pc[r_rd] : '0;
  // live outstanding requests are consecutive words ending just below fpc
  assign w_rsp_pc   = r_fpc - 32'({r_outst, 2'b00});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_fpc   <= RESET_PC;
      r_outst <= '0;
      r_disc  <= '0;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_run   <= 1'b1;
      r_fpc   <= w_redir ? (jmp_addr & 32'hFFFF_FFFC) : r_fpc + (w_gnt ? 32'd4 : 32'd0);
      // every request still in flight after a redirect must be discarded
      r_disc  <= w_redir ? r_disc + r_outst + CW'(w_gnt) - CW'(imem_rvalid) : r_disc - CW'(w_drop);
      r_outst <= w_redir ? '0 : r_outst + CW'(w_gnt) - CW'(w_push);
      r_count <= w_redir ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      r_rd    <= w_redir ? '0 : r_rd + AW'(w_pop);
      r_wr    <= w_redir ? '0 : r_wr + AW'(w_push);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr]   <= w_rsp_pc;
      r_word[r_wr] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: queue-based fetch model plus in-order latency memory agent, directed and random stimulus.
module tb_ifetch;
  localparam int D = 2;
  logic        clk = 0, rst_n = 1;
  logic        imem_gnt = 0, imem_rvalid = 0, is_jmp = 0, inst_ready = 0;
  logic [31:0] imem_rdata = 0, jmp_addr = 0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, PC;
  always #5 clk = ~clk;
  ifetch #(.RESET_PC(32'h0), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .is_jmp(is_jmp), .jmp_addr(jmp_addr), .inst(inst), .PC(PC),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );
  typedef struct {logic [31:0] pc; logic sq;} out_t;
  typedef struct {logic [31:0] pc; logic [31:0] w;} ent_t;
  typedef struct {logic [31:0] a; int due;} mem_t;
  out_t q_out[$];
  ent_t q_buf[$];
  ent_t deliv[$];
  mem_t mem_q[$];
  logic [31:0] m_fpc = 0;
  int cyc = 0, last_due = 0, lat = 1, n_gnt = 0, n_redir = 0, pass_n = 0, tot_n = 0;
  int gp, rp, jp;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  task automatic drive_rsp();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1;
      imem_rdata  = mem_q[0].a + 32'h1000;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 0;
      imem_rdata  = $urandom;
    end
  endtask
  task automatic step();
    logic e_req, e_val, g, pop, redir, rv;
    logic [31:0] a, rd, ja;
    ent_t hd;
    out_t o;
    @(negedge clk);
    e_req = (q_out.size() + q_buf.size()) < D;
    e_val = q_buf.size() > 0;
    hd = '{pc: 32'h0, w: 32'h0};
    if (e_val) hd = q_buf[0];
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_fpc);
    chk("inst_valid", 32'(inst_valid), 32'(e_val));
    chk("PC", PC, hd.pc);
    chk("inst", inst, hd.w);
    g = e_req && imem_gnt;
    pop = e_val && inst_ready;
    redir = pop && is_jmp;
    rv = imem_rvalid;
    rd = imem_rdata;
    a = imem_addr;
    ja = jmp_addr;
    @(posedge clk);
    if (pop) begin
      deliv.push_back(q_buf[0]);
      void'(q_buf.pop_front());
    end
    if (rv) begin
      if (q_out.size() == 0) begin
        tot_n++;
        $display("FAIL rsp_orphan: response with nothing outstanding (cycle %0d)", cyc);
      end else begin
        o = q_out.pop_front();
        if (!o.sq && !redir) q_buf.push_back('{pc: o.pc, w: rd});
      end
    end
    if (g) begin
      q_out.push_back('{pc: m_fpc, sq: 1'b0});
      m_fpc += 4;
      n_gnt++;
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      mem_q.push_back('{a: a, due: last_due});
    end
    if (redir) begin
      foreach (q_out[i]) q_out[i].sq = 1'b1;
      q_buf.delete();
      m_fpc = ja & 32'hFFFF_FFFC;
      n_redir++;
    end
    cyc++;
    #1 drive_rsp();
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    imem_gnt = 0; inst_ready = 0; is_jmp = 0; imem_rvalid = 0;
    #1;
    chk("rst_async_req", 32'(imem_req), 0);
    chk("rst_async_valid", 32'(inst_valid), 0);
    q_out.delete(); q_buf.delete(); mem_q.delete(); deliv.delete();
    m_fpc = 0; last_due = cyc; n_gnt = 0; n_redir = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", PC, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("rel_req", 32'(imem_req), 1);
    chk("rel_addr", imem_addr, 0);
  endtask
  initial begin
    do_reset();
    lat = 1; imem_gnt = 1; inst_ready = 1;
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", deliv[i].pc, 32'(4 * i));
      chk("stream_inst", deliv[i].w, 32'(4 * i) + 32'h1000);
    end
    do_reset();
    imem_gnt = 1; inst_ready = 0;
    repeat (5) step();
    chk("bp_grants", 32'(n_gnt), 2);
    chk("bp_valid", 32'(inst_valid), 1);
    chk("bp_pc", PC, 0);
    chk("bp_inst", inst, 32'h1000);
    inst_ready = 1;
    repeat (8) step();
    for (int i = 0; i < 3; i++) chk("bp_order", deliv[i].pc, 32'(4 * i));
    do_reset();
    lat = 3; imem_gnt = 1; inst_ready = 1; jmp_addr = 32'h103; is_jmp = 1;
    for (int i = 0; i < 20 && n_redir == 0; i++) step();
    is_jmp = 0;
    chk("rd_fired", 32'(n_redir), 1);
    chk("rd_jump_pc", deliv[deliv.size() - 1].pc, 0);
    chk("rd_addr", imem_addr, 32'h100);
    deliv.delete();
    repeat (15) step();
    chk("rd_first_pc", deliv[0].pc, 32'h100);
    chk("rd_first_inst", deliv[0].w, 32'h1100);
    chk("rd_second_pc", deliv[1].pc, 32'h104);
    jmp_addr = 32'hFFFF_FFFF; is_jmp = 1;
    for (int i = 0; i < 20 && n_redir == 1; i++) step();
    is_jmp = 0;
    chk("wrap_fired", 32'(n_redir), 2);
    deliv.delete();
    repeat (15) step();
    chk("wrap_pc0", deliv[0].pc, 32'hFFFF_FFFC);
    chk("wrap_inst0", deliv[0].w, 32'h0000_0FFC);
    chk("wrap_pc1", deliv[1].pc, 32'h0000_0000);
    for (int b = 0; b < 20; b++) begin
      if (b % 5 == 4) do_reset();
      lat = $urandom_range(1, 4);
      gp = $urandom_range(20, 100);
      rp = $urandom_range(10, 100);
      jp = $urandom_range(0, 15);
      repeat (150) begin
        imem_gnt   = ($urandom_range(0, 99) < gp);
        inst_ready = ($urandom_range(0, 99) < rp);
        is_jmp     = ($urandom_range(0, 99) < jp);
        jmp_addr   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        step();
      end
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", pass_n, tot_n);
    $fatal(1);
  end
endmodule
